// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the two-leader bus arbiter:
//   arb_state_t             - arbiter FSM state encoding (IDLE / READ_WAIT)
//   DEFAULT_TIMEOUT_CYCLES  - default read timeout in cycles
//   DEFAULT_READ_DATA_C     - default data returned on a timed-out read
//   cnt_width()             - width of a saturating timeout counter
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      READ_WAIT = 1'b1
   } arb_state_t;

   localparam int          DEFAULT_TIMEOUT_CYCLES = 16;
   localparam logic [31:0] DEFAULT_READ_DATA_C    = 32'hDEAD_BEEF;

   // One extra bit over $clog2 so the counter can hold TIMEOUT_CYCLES-1
   // and still saturate instead of wrapping.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles) + 1;
   endfunction

endpackage

// File: rtl/bus_arbiter_rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic, purely combinational.
//   req[1:0]   - request lines, bit i = leader i requesting
//   last       - index of the leader granted most recently
//   grant[1:0] - one-hot grant (all zero when nobody requests)
// ---------------------------------------------------------------------------
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // Contention: the leader that did not win last time goes first.
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Arbitrates two bus leaders onto one downstream follower. Writes complete in
// the grant cycle; reads hold the bus in READ_WAIT until the follower returns
// read data or the timeout expires (then DEFAULT_READ_DATA is returned and
// timeout_err pulses for one cycle).
//
// Handshake: a leader presents read_req/write_req with its fields; in a cycle
// where its stall is 0 the request is accepted and the leader may move on.
// While stall is 1 the leader holds its request stable. Read data is valid
// only in the cycle its read_data_valid is 1.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   i_leaderN_address/read_req/write_req/byte_enable/write_data  leader N req
//   o_leaderN_read_data/read_data_valid                          leader N resp
//   stall0, stall1               request not accepted this cycle
//   o_target_address/read_req/write_req/byte_enable/write_data   downstream
//   i_target_read_data/read_data_valid                           downstream
//   timeout_err                  one-cycle pulse on an aborted read
//   o_state                      current FSM state (debug)
// ---------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES    = DEFAULT_TIMEOUT_CYCLES,
   parameter logic [31:0] DEFAULT_READ_DATA = DEFAULT_READ_DATA_C
) (
   input  logic        clk,
   input  logic        reset_n,
   // leader0
   input  logic [31:0] i_leader0_address,
   input  logic        i_leader0_read_req,
   input  logic        i_leader0_write_req,
   input  logic [3:0]  i_leader0_byte_enable,
   input  logic [31:0] i_leader0_write_data,
   output logic [31:0] o_leader0_read_data,
   output logic        o_leader0_read_data_valid,
   // leader1
   input  logic [31:0] i_leader1_address,
   input  logic        i_leader1_read_req,
   input  logic        i_leader1_write_req,
   input  logic [3:0]  i_leader1_byte_enable,
   input  logic [31:0] i_leader1_write_data,
   output logic [31:0] o_leader1_read_data,
   output logic        o_leader1_read_data_valid,
   // stalls
   output logic        stall0,
   output logic        stall1,
   // target
   output logic [31:0] o_target_address,
   output logic        o_target_read_req,
   output logic        o_target_write_req,
   output logic [3:0]  o_target_byte_enable,
   output logic [31:0] o_target_write_data,
   input  logic [31:0] i_target_read_data,
   input  logic        i_target_read_data_valid,
   // status
   output logic        timeout_err,
   output arb_state_t  o_state
);

   localparam int            CW      = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CW-1:0] LP_LAST = CW'(TIMEOUT_CYCLES - 1);

   arb_state_t    r_state;
   arb_state_t    w_next_state;
   logic          r_owner;
   logic          r_last;
   logic [CW-1:0] r_count;

   logic [1:0]    w_req;
   logic [1:0]    w_grant;
   logic          w_sel;
   logic          w_sel_rd;
   logic          w_done;
   logic [31:0]   w_done_data;

   assign w_req = {i_leader1_read_req | i_leader1_write_req,
                   i_leader0_read_req | i_leader0_write_req};

   rr_arbiter2 u_rr (
      .req   (w_req),
      .last  (r_last),
      .grant (w_grant)
   );

   assign w_sel    = w_grant[1];
   assign w_sel_rd = w_sel ? i_leader1_read_req : i_leader0_read_req;
   assign o_state  = r_state;

   always_comb begin
      w_next_state              = r_state;
      o_target_address          = '0;
      o_target_read_req         = 1'b0;
      o_target_write_req        = 1'b0;
      o_target_byte_enable      = '0;
      o_target_write_data       = '0;
      stall0                    = w_req[0];
      stall1                    = w_req[1];
      o_leader0_read_data       = '0;
      o_leader0_read_data_valid = 1'b0;
      o_leader1_read_data       = '0;
      o_leader1_read_data_valid = 1'b0;
      timeout_err               = 1'b0;
      w_done                    = 1'b0;
      w_done_data               = '0;

      case (r_state)
         IDLE: begin
            if (|w_grant) begin
               o_target_address     = w_sel ? i_leader1_address     : i_leader0_address;
               o_target_read_req    = w_sel ? i_leader1_read_req    : i_leader0_read_req;
               o_target_write_req   = w_sel ? i_leader1_write_req   : i_leader0_write_req;
               o_target_byte_enable = w_sel ? i_leader1_byte_enable : i_leader0_byte_enable;
               o_target_write_data  = w_sel ? i_leader1_write_data  : i_leader0_write_data;
               if (w_sel) stall1 = 1'b0;
               else       stall0 = 1'b0;
               if (w_sel_rd) w_next_state = READ_WAIT;
            end
         end
         READ_WAIT: begin
            // Real data beats the timeout when both land in the same cycle.
            if (i_target_read_data_valid) begin
               w_done       = 1'b1;
               w_done_data  = i_target_read_data;
               w_next_state = IDLE;
            end else if (r_count == LP_LAST) begin
               w_done       = 1'b1;
               w_done_data  = DEFAULT_READ_DATA;
               timeout_err  = reset_n;
               w_next_state = IDLE;
            end
         end
         default: w_next_state = IDLE;
      endcase

      // A reset during READ_WAIT abandons the read: no response escapes.
      if (w_done && reset_n) begin
         if (r_owner) begin
            o_leader1_read_data       = w_done_data;
            o_leader1_read_data_valid = 1'b1;
         end else begin
            o_leader0_read_data       = w_done_data;
            o_leader0_read_data_valid = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_owner <= 1'b0;
         r_last  <= 1'b1;  // "leader1 went last" gives leader0 priority
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == IDLE && (|w_grant)) begin
            r_last <= w_sel;
            if (w_sel_rd) begin
               r_owner <= w_sel;
               r_count <= '0;
            end
         end else if (r_state == READ_WAIT && !i_target_read_data_valid &&
                      r_count != '1) begin
            r_count <= r_count + CW'(1);
         end
      end
   end

endmodule
